// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: combinational enables for PC, IF/ID and ID/EX,
// plus registered state, saturating event counters and a sticky stall watchdog.
module hazard_stall_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req_lu,
  input  logic             stall_req_beq,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ext_hold,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] stall_events,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_timeout
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HOLD = 2'd2} state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam int                RL_W    = $clog2(MAX_STALL + 1);
  localparam logic [RL_W-1:0]   RL_MAX  = RL_W'(MAX_STALL);
  localparam logic [RL_W-1:0]   RL_ONE  = {{(RL_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t          cur, nxt;
  ctrl_t           ctrl;
  logic            hz, redir;
  logic [RL_W-1:0] run_len, run_len_nxt;
  logic            in_episode;

  assign hz    = stall_req_lu | stall_req_beq;
  assign redir = branch_taken | jump;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Priority: memory hold freezes everything, then hazards, then redirects.
  always_comb begin
    ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
    nxt  = RUN;
    if (ext_hold) begin
      ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
      nxt  = HOLD;
    end else if (hz) begin
      ctrl = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
      nxt  = STALL;
    end else if (redir) begin
      ctrl.if_id_flush = 1'b1;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign state        = cur;

  always_comb begin
    run_len_nxt = run_len;
    if (!ext_hold) begin
      if (!hz)                  run_len_nxt = '0;
      else if (run_len != RL_MAX) run_len_nxt = run_len + RL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= RUN;
    else      cur <= nxt;
  end

  // in_episode survives HOLD so a stall split by a memory hold stays one event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= '0;
      stall_events  <= '0;
      flush_count   <= '0;
      stall_timeout <= 1'b0;
      run_len       <= '0;
      in_episode    <= 1'b0;
    end else begin
      run_len <= run_len_nxt;
      if (!ext_hold) begin
        in_episode <= hz;
        if (hz) begin
          stall_cycles <= sat_inc(stall_cycles);
          if (!in_episode) stall_events <= sat_inc(stall_events);
          if (run_len_nxt == RL_MAX) stall_timeout <= 1'b1;
        end else if (redir) begin
          flush_count <= sat_inc(flush_count);
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an integer reference model.
module tb_hazard_stall_ctrl;
  localparam int MAXS = 4;
  localparam int WA   = 8;
  localparam int WB   = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic lu = 1'b0, beq = 1'b0, bt = 1'b0, jmp = 1'b0, hold = 1'b0;

  logic a_pc, a_ifw, a_fl, a_bub, a_to;
  logic [1:0] a_st;
  logic [WA-1:0] a_cyc, a_ev, a_fc;
  logic b_pc, b_ifw, b_fl, b_bub, b_to;
  logic [1:0] b_st;
  logic [WB-1:0] b_cyc, b_ev, b_fc;

  int checks = 0, failures = 0;

  hazard_stall_ctrl #(.CNT_W(WA), .MAX_STALL(MAXS)) u_a (
    .clk(clk), .rst(rst), .stall_req_lu(lu), .stall_req_beq(beq), .branch_taken(bt),
    .jump(jmp), .ext_hold(hold), .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_fl),
    .id_ex_bubble(a_bub), .state(a_st), .stall_cycles(a_cyc), .stall_events(a_ev),
    .flush_count(a_fc), .stall_timeout(a_to));

  hazard_stall_ctrl #(.CNT_W(WB), .MAX_STALL(MAXS)) u_b (
    .clk(clk), .rst(rst), .stall_req_lu(lu), .stall_req_beq(beq), .branch_taken(bt),
    .jump(jmp), .ext_hold(hold), .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_fl),
    .id_ex_bubble(b_bub), .state(b_st), .stall_cycles(b_cyc), .stall_events(b_ev),
    .flush_count(b_fc), .stall_timeout(b_to));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: raw unbounded event tallies; saturation applied at compare time.
  int m_state = 0, m_cyc = 0, m_ev = 0, m_fl = 0, m_run = 0;
  bit m_inep = 1'b0, m_to = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 0; m_cyc <= 0; m_ev <= 0; m_fl <= 0; m_run <= 0;
      m_inep <= 1'b0; m_to <= 1'b0;
    end else if (hold) begin
      m_state <= 2;
    end else if (lu || beq) begin
      m_state <= 1;
      m_cyc   <= m_cyc + 1;
      if (!m_inep) m_ev <= m_ev + 1;
      m_inep  <= 1'b1;
      m_run   <= m_run + 1;
      if (m_run + 1 >= MAXS) m_to <= 1'b1;
    end else begin
      m_state <= 0;
      m_run   <= 0;
      m_inep  <= 1'b0;
      if (bt || jmp) m_fl <= m_fl + 1;
    end
  end

  always @(negedge clk) begin
    int e_pc, e_ifw, e_fl, e_bub;
    e_pc  = (!hold && !(lu || beq)) ? 1 : 0;
    e_ifw = e_pc;
    e_fl  = (e_pc == 1 && (bt || jmp)) ? 1 : 0;
    e_bub = (!hold && (lu || beq)) ? 1 : 0;
    chk("a_pc_write", a_pc, e_pc);     chk("b_pc_write", b_pc, e_pc);
    chk("a_if_id_write", a_ifw, e_ifw); chk("b_if_id_write", b_ifw, e_ifw);
    chk("a_if_id_flush", a_fl, e_fl);   chk("b_if_id_flush", b_fl, e_fl);
    chk("a_id_ex_bubble", a_bub, e_bub); chk("b_id_ex_bubble", b_bub, e_bub);
    chk("a_state", a_st, m_state);      chk("b_state", b_st, m_state);
    chk("a_timeout", a_to, m_to);       chk("b_timeout", b_to, m_to);
    chk("a_stall_cycles", a_cyc, sat(m_cyc, WA)); chk("b_stall_cycles", b_cyc, sat(m_cyc, WB));
    chk("a_stall_events", a_ev, sat(m_ev, WA));   chk("b_stall_events", b_ev, sat(m_ev, WB));
    chk("a_flush_count", a_fc, sat(m_fl, WA));    chk("b_flush_count", b_fc, sat(m_fl, WB));
  end

  task automatic drive(input logic l, input logic b, input logic t, input logic j, input logic h);
    lu = l; beq = b; bt = t; jmp = j; hold = h;
  endtask
  task automatic mid();   @(negedge clk); #1; endtask
  task automatic tick();  @(posedge clk); #1; endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int p_hz;
    // Reset then idle
    tick(); tick();
    chk("rst_cycles", a_cyc, 0);
    rst = 1'b1;
    repeat (5) tick();
    chk("idle_pc_write", a_pc, 1); chk("idle_if_id_write", a_ifw, 1);
    chk("idle_state", a_st, 0);    chk("idle_events", a_ev, 0);
    chk("idle_flush", a_fc, 0);    chk("idle_timeout", a_to, 0);

    // Single-cycle load-use stall
    drive(1, 0, 0, 0, 0); mid();
    chk("lu_pc_write", a_pc, 0); chk("lu_if_id_write", a_ifw, 0); chk("lu_bubble", a_bub, 1);
    tick();
    chk("lu_cycles", a_cyc, 1); chk("lu_events", a_ev, 1); chk("lu_state", a_st, 1);
    drive(0, 0, 0, 0, 0); tick();
    chk("lu_back_run", a_st, 0);

    // Branch hazard masks taken branch until operands resolve
    do_reset();
    drive(0, 1, 1, 0, 0);
    repeat (2) begin mid(); chk("beq_no_flush", a_fl, 0); chk("beq_bubble", a_bub, 1); tick(); end
    drive(0, 0, 1, 0, 0); mid();
    chk("beq_flush", a_fl, 1); chk("beq_pc_write", a_pc, 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("beq_flush_count", a_fc, 1); chk("beq_cycles", a_cyc, 2); chk("beq_events", a_ev, 1);

    // Stall split by hold: one episode, watchdog at the 4th hz cycle
    do_reset();
    drive(1, 0, 0, 0, 0); repeat (3) tick();
    chk("wd_not_yet", a_to, 0);
    drive(1, 0, 0, 0, 1);
    repeat (2) begin mid(); chk("hold_no_bubble", a_bub, 0); chk("hold_pc_write", a_pc, 0); tick(); end
    chk("hold_state", a_st, 2); chk("hold_wd_not_yet", a_to, 0);
    drive(0, 1, 0, 0, 0); tick();
    chk("wd_set", a_to, 1);
    tick(); drive(0, 0, 0, 0, 0); tick();
    chk("wd_sticky", a_to, 1); chk("split_events", a_ev, 1); chk("split_cycles", a_cyc, 5);

    // Jump frozen by hold, then flushes
    do_reset();
    drive(0, 0, 0, 1, 1); mid();
    chk("jh_flush", a_fl, 0); chk("jh_pc_write", a_pc, 0); chk("jh_if_id_write", a_ifw, 0);
    tick(); drive(0, 0, 0, 1, 0); mid();
    chk("j_flush", a_fl, 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("j_flush_count", a_fc, 1);

    // Saturation on the narrow instance, then reset mid-stall
    do_reset();
    repeat (5) begin drive(1, 0, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0); tick(); end
    chk("sat_b_events", b_ev, 3); chk("sat_a_events", a_ev, 5);
    chk("sat_b_cycles", b_cyc, 3); chk("sat_a_cycles", a_cyc, 5);
    drive(1, 0, 0, 0, 0); mid();
    rst = 1'b0; #1;
    chk("midrst_b_events", b_ev, 0); chk("midrst_a_cycles", a_cyc, 0); chk("midrst_state", a_st, 0);
    tick(); rst = 1'b1; tick();
    chk("post_rst_events", a_ev, 1);
    drive(0, 0, 0, 0, 0); tick();

    // Randomized traffic with varying hazard density
    for (int seg = 0; seg < 50; seg++) begin
      case ($urandom_range(2))
        0:       p_hz = 10;
        1:       p_hz = 50;
        default: p_hz = 90;
      endcase
      for (int c = 0; c < 60; c++) begin
        rst  = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
        hold = ($urandom_range(99) < 12);
        lu   = ($urandom_range(99) < p_hz / 2);
        beq  = ($urandom_range(99) < p_hz / 2);
        bt   = ($urandom_range(99) < 30);
        jmp  = ($urandom_range(99) < 15);
        tick();
      end
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
